// File: rtl/keypad_pkg.sv
// Shared types and keymap for the 4x4 keypad scanner.
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Consecutive empty scans needed in RELEASED before a press may start.
   localparam int unsigned QUAL_SCANS = 4;

   typedef enum logic [1:0] {
      StReleased,
      StPressDeb,
      StHeld,
      StReleaseDeb
   } kp_state_e;

   typedef enum logic [1:0] {
      ScanNone,
      ScanOne,
      ScanMulti
   } scan_kind_e;

   typedef struct packed {
      scan_kind_e kind;
      logic [3:0] code;
   } scan_res_t;

   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      if (col == 2'd3) begin
         code = 4'hA + {2'b00, row};
      end else if (row != 2'd3) begin
         code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
      end else begin
         unique case (col)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'h0;
            default: code = KEY_HASH;
         endcase
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake bundle between the scanner and its consumer.
interface keypad_scanner_if;

   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       key_held;
   logic       key_drop;

   modport master (
      output key_code,
      output key_valid,
      output key_held,
      output key_drop,
      input  key_ready
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  key_held,
      input  key_drop,
      output key_ready
   );

endinterface

// File: rtl/keypad_debounce.sv
// Whole-scan debounce FSM: turns per-scan results into press events.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debounce import keypad_pkg::*; #(
   parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int unsigned REPEAT_SCANS = 64
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_strobe,
   input  scan_res_t  scan_res,
   output logic       press_evt,
   output logic [3:0] press_code,
   output logic       key_held
);

   localparam logic [3:0] DebN  = 4'(DEBOUNCE_SCANS);
   localparam logic [2:0] QualN = 3'(QUAL_SCANS);

   kp_state_e  state_q, state_d;
   logic [3:0] code_q, code_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] qual_q, qual_d;
   logic       is_none, is_one, is_match;

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned RepW = $clog2(2 * REPEAT_SCANS + 1);
   logic [RepW-1:0] rep_q, rep_d;
`endif

   assign is_none    = (scan_res.kind == ScanNone);
   assign is_one     = (scan_res.kind == ScanOne);
   assign is_match   = is_one && (scan_res.code == code_q);
   assign press_code = scan_res.code;
   assign key_held   = (state_q == StHeld) || (state_q == StReleaseDeb);

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      qual_d    = qual_q;
      press_evt = 1'b0;
      if (scan_strobe) begin
         unique case (state_q)
            StReleased: begin
               if (qual_q != QualN) begin
                  qual_d = is_none ? qual_q + 3'd1 : 3'd0;
               end else if (is_one) begin
                  code_d = scan_res.code;
                  cnt_d  = 4'd1;
                  if (DebN == 4'd1) begin
                     state_d   = StHeld;
                     press_evt = 1'b1;
                  end else begin
                     state_d = StPressDeb;
                  end
               end
            end
            StPressDeb: begin
               if (is_match) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_d == DebN) begin
                     state_d   = StHeld;
                     press_evt = 1'b1;
                  end
               end else if (is_one) begin
                  // A different single key restarts qualification with itself.
                  code_d = scan_res.code;
                  cnt_d  = 4'd1;
               end else begin
                  cnt_d = 4'd0;
               end
            end
            StHeld: begin
               if (!is_match) begin
                  state_d = StReleaseDeb;
                  cnt_d   = is_none ? 4'd1 : 4'd0;
                  if (is_none && (DebN == 4'd1)) begin
                     state_d = StReleased;
                     qual_d  = 3'd0;
                  end
               end
            end
            StReleaseDeb: begin
               if (is_match) begin
                  state_d = StHeld;
               end else if (is_none) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_d == DebN) begin
                     state_d = StReleased;
                     qual_d  = 3'd0;
                  end
               end else begin
                  cnt_d = 4'd0;
               end
            end
            default: state_d = StReleased;
         endcase
      end

`ifdef KEYPAD_REPEAT_EN
      // First repeat after 2*REPEAT_SCANS held scans, then every REPEAT_SCANS.
      rep_d = rep_q;
      if (scan_strobe) begin
         if ((state_q == StHeld) && is_match) begin
            if (rep_q == RepW'(2 * REPEAT_SCANS - 1)) begin
               press_evt = 1'b1;
               rep_d     = RepW'(REPEAT_SCANS);
            end else begin
               rep_d = rep_q + 1'b1;
            end
         end else if (press_evt) begin
            rep_d = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StReleased;
         code_q  <= 4'd0;
         cnt_q   <= 4'd0;
         qual_q  <= 3'd0;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         qual_q  <= qual_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, column sync, scan classification, event handshake.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner import keypad_pkg::*; #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int unsigned REPEAT_SCANS   = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic [3:0]              keypad_rows,
   input  logic [3:0]              keypad_cols,
   keypad_scanner_if.master        key_if
);

   localparam int unsigned SlotW = $clog2(SCAN_DIV);

   logic [SlotW-1:0] slot_q;
   logic [1:0]       row_q;
   logic [3:0]       sync1_q, sync2_q;
   logic [1:0]       acc_cnt_q, acc_cnt_d;
   logic [3:0]       acc_code_q, acc_code_d;
   logic             slot_last, scan_strobe;
   logic [3:0]       low;
   logic [2:0]       row_cnt, sum;
   logic [1:0]       row_col;
   scan_res_t        scan_res;

   logic             press_evt, held;
   logic [3:0]       press_code;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d, drop_q, drop_d;

   assign keypad_rows = ~(4'b0001 << row_q);
   assign slot_last   = (slot_q == SlotW'(SCAN_DIV - 1));
   assign scan_strobe = slot_last && (row_q == 2'd3);
   assign low         = ~sync2_q;

   // Fold this row's sample into the running scan; saturate the key count at 2.
   always_comb begin
      row_cnt = 3'd0;
      row_col = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (low[i]) begin
            row_cnt = row_cnt + 3'd1;
            row_col = 2'(i);
         end
      end
      sum        = ((row_q == 2'd0) ? 3'd0 : {1'b0, acc_cnt_q}) + row_cnt;
      acc_cnt_d  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      acc_code_d = (row_cnt == 3'd1) ? keymap(row_q, row_col) : acc_code_q;
      unique case (acc_cnt_d)
         2'd0:    scan_res.kind = ScanNone;
         2'd1:    scan_res.kind = ScanOne;
         default: scan_res.kind = ScanMulti;
      endcase
      scan_res.code = acc_code_d;
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
      ,
      .REPEAT_SCANS(REPEAT_SCANS)
`endif
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_strobe(scan_strobe),
      .scan_res   (scan_res),
      .press_evt  (press_evt),
      .press_code (press_code),
      .key_held   (held)
   );

   always_comb begin
      valid_d = valid_q;
      code_d  = code_q;
      drop_d  = 1'b0;
      if (valid_q && key_if.key_ready) valid_d = 1'b0;
      if (press_evt) begin
         if (!valid_q || key_if.key_ready) begin
            valid_d = 1'b1;
            code_d  = press_code;
         end else begin
            drop_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q     <= '0;
         row_q      <= 2'd0;
         sync1_q    <= 4'b1111;
         sync2_q    <= 4'b1111;
         acc_cnt_q  <= 2'd0;
         acc_code_q <= 4'd0;
         code_q     <= 4'd0;
         valid_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         sync1_q <= keypad_cols;
         sync2_q <= sync1_q;
         if (slot_last) begin
            slot_q     <= '0;
            row_q      <= row_q + 2'd1;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
         end else begin
            slot_q <= slot_q + SlotW'(1);
         end
         code_q  <= code_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign key_if.key_code  = code_q;
   assign key_if.key_valid = valid_q;
   assign key_if.key_drop  = drop_q;
   assign key_if.key_held  = held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed/randomized bench for keypad_scanner with a behavioural keypad and keymap model.
module tb_keypad_scanner;

   localparam int ScanDiv = 4;
   localparam int ScanCyc = 4 * ScanDiv;
   localparam int LatMax  = 3 * ScanCyc + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [15:0] keys = '0;

   int n_chk = 0;
   int n_fail = 0;
   int drops = 0;
   logic [3:0] got[$];

   keypad_scanner_if kif ();

   keypad_scanner #(
      .SCAN_DIV      (ScanDiv),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keypad_rows(rows),
      .keypad_cols(cols),
      .key_if     (kif)
   );

   always #5 clk = ~clk;

   // Pressed key at (r,c) pulls column c low while row r is driven low.
   always_comb begin
      cols = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
   end

   always @(posedge clk) begin
      if (kif.key_valid && kif.key_ready) got.push_back(kif.key_code);
      if (kif.key_drop) drops <= drops + 1;
   end

   function automatic logic [3:0] model_code(input int idx);
      string legend;
      byte   ch;
      legend = "123A456B789C*0#D";
      ch = legend[idx];
      if (ch >= "0" && ch <= "9") return 4'(ch - "0");
      if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
      if (ch == "*") return 4'hE;
      return 4'hF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input int bound, output logic ok);
      int lat = 0;
      while (!kif.key_valid && lat < bound) begin
         @(negedge clk);
         lat++;
      end
      ok = kif.key_valid;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rows"}, 32'(rows), 32'h0000_000E);
      chk({tag, "_code"}, 32'(kif.key_code), 32'd0);
      chk({tag, "_valid"}, 32'(kif.key_valid), 32'd0);
      chk({tag, "_held"}, 32'(kif.key_held), 32'd0);
      chk({tag, "_drop"}, 32'(kif.key_drop), 32'd0);
   endtask

   initial begin
      int   base, d0, idx;
      logic ok;
      kif.key_ready = 1'b1;
      cycles(3);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 2 * ScanCyc; i++) begin
         chk("rows_cycle", 32'(rows), 32'(4'(~(32'd1 << ((i / ScanDiv) % 4)))));
         if (kif.key_valid) chk("idle_valid", 32'(kif.key_valid), 32'd0);
         @(negedge clk);
      end
      cycles(4 * ScanCyc);

      // Single press of "5"
      base = got.size(); d0 = drops;
      cycles($urandom_range(0, 15));
      keys[5] = 1'b1;
      wait_valid(LatMax, ok);
      chk("five_latency", 32'(ok), 32'd1);
      chk("five_code", 32'(kif.key_code), 32'h5);
      @(negedge clk);
      chk("five_pulse", 32'(kif.key_valid), 32'd0);
      cycles(ScanCyc * $urandom_range(1, 4));
      chk("five_held", 32'(kif.key_held), 32'd1);
      keys[5] = 1'b0;
      cycles(ScanCyc);
      chk("five_held_rel", 32'(kif.key_held), 32'd1);
      cycles(7 * ScanCyc);
      chk("five_released", 32'(kif.key_held), 32'd0);
      chk("five_count", 32'(got.size() - base), 32'd1);
      if (got.size() > base) chk("five_got", 32'(got[base]), 32'h5);
      chk("five_nodrop", 32'(drops - d0), 32'd0);

      // Random single keys against the keymap model
      for (int k = 0; k < 4; k++) begin
         base = got.size();
         idx = int'($urandom_range(0, 15));
         cycles($urandom_range(0, 15));
         keys[idx] = 1'b1;
         wait_valid(LatMax, ok);
         chk("rand_latency", 32'(ok), 32'd1);
         chk("rand_code", 32'(kif.key_code), 32'(model_code(idx)));
         cycles(ScanCyc * $urandom_range(1, 3));
         keys[idx] = 1'b0;
         cycles(8 * ScanCyc);
         chk("rand_count", 32'(got.size() - base), 32'd1);
      end

      // "#" with a one-scan bounce
      base = got.size();
      cycles($urandom_range(0, 15));
      keys[14] = 1'b1; cycles(ScanCyc);
      keys[14] = 1'b0; cycles(ScanCyc);
      keys[14] = 1'b1;
      wait_valid(LatMax, ok);
      chk("hash_latency", 32'(ok), 32'd1);
      chk("hash_code", 32'(kif.key_code), 32'hF);
      cycles(3 * ScanCyc);
      keys[14] = 1'b0;
      cycles(8 * ScanCyc);
      chk("hash_count", 32'(got.size() - base), 32'd1);

      // "1" and "9" together, then release "9"
      base = got.size();
      keys[0] = 1'b1; keys[10] = 1'b1;
      cycles(6 * ScanCyc);
      chk("multi_valid", 32'(kif.key_valid), 32'd0);
      chk("multi_held", 32'(kif.key_held), 32'd0);
      chk("multi_count", 32'(got.size() - base), 32'd0);
      keys[10] = 1'b0;
      wait_valid(LatMax, ok);
      chk("one_latency", 32'(ok), 32'd1);
      chk("one_code", 32'(kif.key_code), 32'h1);
      cycles(2 * ScanCyc);
      keys[0] = 1'b0;
      cycles(8 * ScanCyc);
      chk("one_count", 32'(got.size() - base), 32'd1);

      // Consumer stalled: "A" then "0" is dropped
      base = got.size(); d0 = drops;
      kif.key_ready = 1'b0;
      keys[3] = 1'b1;
      wait_valid(LatMax, ok);
      chk("a_latency", 32'(ok), 32'd1);
      chk("a_code", 32'(kif.key_code), 32'hA);
      cycles(2 * ScanCyc);
      keys[3] = 1'b0;
      cycles(8 * ScanCyc);
      chk("a_pending", 32'(kif.key_valid), 32'd1);
      keys[13] = 1'b1;
      cycles(5 * ScanCyc);
      chk("drop_count", 32'(drops - d0), 32'd1);
      chk("drop_code_kept", 32'(kif.key_code), 32'hA);
      chk("drop_valid", 32'(kif.key_valid), 32'd1);
      chk("zero_held", 32'(kif.key_held), 32'd1);
      keys[13] = 1'b0;
      cycles(8 * ScanCyc);
      kif.key_ready = 1'b1;
      @(negedge clk);
      chk("a_accepted", 32'(kif.key_valid), 32'd0);
      chk("a_count", 32'(got.size() - base), 32'd1);
      if (got.size() > base) chk("a_got", 32'(got[base]), 32'hA);
      chk("drop_total", 32'(drops - d0), 32'd1);

      // Reset while "7" held with an event pending
      kif.key_ready = 1'b0;
      keys[8] = 1'b1;
      wait_valid(LatMax, ok);
      chk("seven_latency", 32'(ok), 32'd1);
      chk("seven_code", 32'(kif.key_code), 32'h7);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      cycles(2);
      rst_n = 1'b1;
      kif.key_ready = 1'b1;
      base = got.size();
      cycles(8 * ScanCyc);
      chk("postrst_valid", 32'(kif.key_valid), 32'd0);
      chk("postrst_held", 32'(kif.key_held), 32'd0);
      chk("postrst_count", 32'(got.size() - base), 32'd0);
      keys[8] = 1'b0;
      cycles(5 * ScanCyc);
      keys[8] = 1'b1;
      wait_valid(LatMax, ok);
      chk("seven2_latency", 32'(ok), 32'd1);
      chk("seven2_code", 32'(kif.key_code), 32'h7);
      cycles(2 * ScanCyc);
      keys[8] = 1'b0;
      cycles(8 * ScanCyc);
      chk("seven2_count", 32'(got.size() - base), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Active 4x4 matrix keypad scanner for the FIFO lab board. Drives the keypad row lines one-hot active-low, samples the column lines, debounces whole-matrix scans, and emits one 4-bit key code per press over a valid/ready handshake. It sources `Data_In`/`push` for the FIFO write side in place of the constant test data, and replaces the tied-off `keypad_rows`.

## Interface
- `SCAN_DIV`, 50000: clk cycles each row is driven (1 ms at 50 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a change; range 1..15.
- `REPEAT_SCANS`, 64: scans between auto-repeat events; only used with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `keypad_rows`  out  4  row drive, one-hot active-low.
- `keypad_cols`  in  4  column sense, active-low with board pull-ups, asynchronous.
- `key_code`  out  4  code of the accepted key; stable while `key_valid` is high.
- `key_valid`  out  1  key event pending.
- `key_ready`  in  1  consumer accepts the event.
- `key_held`  out  1  debounced state: exactly one key is down.
- `key_drop`  out  1  one-cycle pulse when an event is lost because the previous event is still pending.

## Operation
- `keypad_cols` pass through a 2-FF synchronizer before any use.
- Row counter 0..3 advances every `SCAN_DIV` cycles and wraps 3->0. `keypad_rows` = ~(1<<row).
- Sample the synchronized columns on the last cycle of each row slot. A full scan spans rows 0..3.
- Scan result: NONE (no column low), ONE(code) (exactly one key in the matrix), or MULTI.
- Keymap (row, col0..3): r0 1 2 3 A; r1 4 5 6 B; r2 7 8 9 C; r3 * 0 # D. Digits map to 0x0-0x9, A-D to 0xA-0xD, * to 0xE, # to 0xF.
- Debounce FSM states:
  - RELEASED: 4 scans of NONE are needed before a new press is accepted.
  - PRESS_DEB: ONE(c) matched for `DEBOUNCE_SCANS` scans -> HELD(c) and emit an event. Any other result resets the count.
  - HELD(c): any non-ONE(c) result -> RELEASE_DEB.
  - RELEASE_DEB: NONE for `DEBOUNCE_SCANS` scans -> RELEASED. ONE(c) -> back to HELD(c) with no event.
  - MULTI never starts or completes a press; it counts as "not NONE" for release.
- `key_held` = 1 in HELD and RELEASE_DEB.
- Handshake rules:
  - An event loads `key_code` and sets `key_valid`.
  - `key_valid && key_ready` clears `key_valid` on the next edge.
  - If an event arrives in the same cycle as an accept, the new code loads and `key_valid` stays 1.
  - If an event arrives while `key_valid && !key_ready`, the event is discarded, `key_code` is unchanged, and `key_drop` pulses.

## Timing
- Reset values: `keypad_rows`=4'b1110, row 0, slot counter 0, FSM RELEASED, `key_code`=0, `key_valid`=0, `key_held`=0, `key_drop`=0, synchronizers 4'b1111.
- Scan period is 4*`SCAN_DIV` cycles. Column sample lag is 2 cycles (synchronizer), which requires `SCAN_DIV`>=4.
- `key_valid` rises 1 cycle after the row-3 sample of the accepting scan.
- Worst-case press latency is (`DEBOUNCE_SCANS`+1) scans + 1 cycle.
- `rst_n` low mid-operation returns every output to its reset value immediately. Any pending event is lost.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HELD, a scan counter re-emits the held code every `REPEAT_SCANS` scans.
  - The first repeat comes 2*`REPEAT_SCANS` scans after acceptance.
  - Repeats follow the same handshake and drop rules.
- `KEYPAD_REPEAT_EN` undefined: exactly one event per press. The repeat counter and `REPEAT_SCANS` logic are absent.

## Structure
- `keypad_pkg` holds:
  - key code constants (`KEY_STAR`=4'hE, `KEY_HASH`=4'hF);
  - the keymap function (row, col -> code);
  - the FSM state typedef;
  - the scan-result encoding.
- One sub-module, `keypad_debounce`: takes the per-scan result and a strobe, and outputs the press event, `key_held` and the accepted code. The scanner top holds the row counter, synchronizer and handshake register.

## Test plan
Bench uses `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=2. The keypad model pulls the column low while its row is driven.
- Reset release, no keys -> rows cycle 1110,1101,1011,0111 every 4 clks; `key_valid`=0.
- Press "5" (r1,c1) held, `key_ready`=1 -> exactly one `key_valid` pulse with `key_code`=4'h5; `key_held`=1 until release completes.
- Press "#" with 1-scan bounce (press, release, press) -> a single event, code 4'hF, after 2 clean scans.
- "1" and "9" pressed together -> no event. Releasing "9" -> event 4'h1.
- `key_ready`=0, press "A", release, then press "0" -> `key_code` stays 4'hA; `key_drop` pulses once at the "0" acceptance.
- Assert `rst_n` low while "7" is held with `key_valid`=1 -> all outputs at reset values that cycle. After release of reset with "7" still held -> a fresh event 4'h7, only after the 4-scan NONE-qualification requirement is met following release.
